reg_mem_mr_wm: RTL and testbench
================================

# reg_mem_mr_wm

Single-clock register-file memory with one masked write port, `READ_PORTS` independent registered read ports, selectable read-during-write behaviour, and a hardware clear sweep that runs after reset and on request. Replaces the two-clock, one-read-port register memory wherever a block needs several same-cycle lookups, such as scoreboards, rename tables and descriptor stores.

## Interface
Parameters:
- `WIDTH`, 32: data bits per row.
- `HEIGHT`, 16: number of rows, at least 2. Address width `AW = $clog2(HEIGHT)`.
- `MASK`, 4: number of write-mask lanes. `CHUNK = ceil(WIDTH/MASK)`. The top lane covers `REST = WIDTH-(MASK-1)*CHUNK` bits. Elaboration fails if `REST < 1`.
- `READ_PORTS`, 2: number of read ports, 1..4.
- `WRITE_FIRST`, 1: 1 = a read of the row being written returns merged new data; 0 = it returns old data.
- `CLEAR_VALUE`, `'0`: `WIDTH`-bit value written to every row by a clear sweep.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `readEnable_i` in `[READ_PORTS]`: per-port read strobe.
- `readAddr_i` in `[READ_PORTS][AW]`: per-port read address.
- `readData_o` out `[READ_PORTS][WIDTH]`: per-port registered read data.
- `writeEnable_i` in 1: write strobe.
- `writeMask_i` in `MASK`: lane enables.
- `writeAddr_i` in `AW`: write address.
- `writeData_i` in `WIDTH`: write data.
- `clear_i` in 1: request a clear sweep.
- `busy_o` out 1: clear sweep in progress.

## Operation
- **Write:** when `writeEnable_i && !busy_o && writeAddr_i < HEIGHT`, each lane `i` with `writeMask_i[i]=1` updates bits `[CHUNK*i +: CHUNK]`. The top lane updates `REST` bits. Unmasked lanes keep their value.
- **Write ignored:** a write with `writeAddr_i >= HEIGHT`, or one issued while `busy_o=1`, is silently dropped.
- **Read:** when `readEnable_i[p]=1`, `readData_o[p]` loads the row at `readAddr_i[p]`. An address `>= HEIGHT` loads all-zero. When `readEnable_i[p]=0`, `readData_o[p]` holds its value.
- **Port independence:** all ports are independent. Any number of ports may read the same address in the same cycle.
- **Read-during-write, `WRITE_FIRST=1`:** a port reading the address being written gets new data in masked lanes and old data in unmasked lanes.
- **Read-during-write, `WRITE_FIRST=0`:** the port gets the old row.
- **Clear FSM states:** `IDLE`, `SWEEP`.
  - `SWEEP` writes `CLEAR_VALUE` to row `clrIdx`, one row per cycle, with all lanes enabled. `clrIdx` increments from 0.
  - After row `HEIGHT-1` is written, the FSM goes to `IDLE`.
  - `busy_o = (state == SWEEP)`.
- **Clear entry:**
  - `IDLE` with `clear_i=1` goes to `SWEEP` with `clrIdx=0`.
  - A user write in that same cycle is still performed, then overwritten by the sweep.
  - `clear_i` during `SWEEP` is ignored and does not restart the sweep.
- **Reads during a sweep** are allowed. A read of row `clrIdx` in the cycle it is swept follows the `WRITE_FIRST` rule: it returns `CLEAR_VALUE` when `WRITE_FIRST=1`.
- **Reset:** `rst_i=1` forces `state=SWEEP`, `clrIdx=0` and `readData_o[*]=0`. The memory array has no reset. It is initialised by the sweep that starts when `rst_i` falls.
- **Reset mid-sweep:** restarts the sweep from row 0.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N+1.
- A write at edge N is visible to a read issued at edge N+1, with no stall.
- With `WRITE_FIRST=1` it is also visible to a read issued at the same edge N.
- **Reset values:** `readData_o = 0`, `busy_o = 1`.
- After `rst_i` is deasserted, `busy_o` stays 1 for exactly `HEIGHT` cycles, then drops.
- `clear_i` sampled at edge N gives `busy_o=1` from after edge N through `HEIGHT` cycles.
- The first user write is accepted at the edge where `busy_o` is 0 on entry.
- There are no combinational paths from inputs to outputs.

## Structure
- **Package `reg_mem_pkg`:**
  - state enum `clr_state_t` (`IDLE`, `SWEEP`);
  - function `chunk(width, mask)`;
  - function `rest(width, mask)`;
  - function `lane_merge(old, new, mask)` returning the masked merge, shared by the write path and forwarding.
- **Sub-module `reg_mem_read_port`:** one instance per read port. It holds the address decode, out-of-range zeroing, `WRITE_FIRST` forwarding mux and output register.
- **Top level:** array, write path, clear FSM and `clrIdx` counter.

## Test plan
- **Reset sweep:** `HEIGHT=16`, pulse `rst_i` for 1 cycle → `busy_o=1` for 16 cycles. Afterwards every port reads `CLEAR_VALUE` at all 16 rows. A write issued during busy has no effect.
- **Masked write:** `WIDTH=32`, `MASK=4`. Write `0xAABBCCDD` mask `4'b1111` to row 3, then `0x11223344` mask `4'b0101` → a read of row 3 returns `0xAA22CC44`.
- **Uneven lanes:** `WIDTH=10`, `MASK=4` (`CHUNK=3`, `REST=1`). Write `10'h3FF` mask `4'b1000` to a zeroed row → returns `10'h200`.
- **Read-during-write:** row 5 holds `0x0`. Write `0xFFFFFFFF` mask `4'b0011` while port 0 and port 1 both read row 5 in the same cycle → both return `0x0000FFFF` with `WRITE_FIRST=1`, and `0x00000000` with `WRITE_FIRST=0`.
- **Clear interactions:** `clear_i` together with a write of `0x5` to row 2 → row 2 reads `CLEAR_VALUE` after the sweep. A second `clear_i` mid-sweep leaves the sweep length at `HEIGHT` cycles.
- **Reset mid-sweep and hold:** assert `rst_i` at sweep row 7 → `readData_o=0` and the sweep restarts at row 0 for a full `HEIGHT` cycles. Port 1 with `readEnable_i=0` holds its last data across writes to that row.

Source files
------------

// File: rtl/reg_mem_pkg.sv
// reg_mem_pkg
//    Shared types and helpers for the multi-read-port register memory:
//    clear-sweep state encoding, write-lane geometry and the masked row merge
//    used by both the array write path and read-during-write forwarding.
package reg_mem_pkg;

   // Upper bounds for the generic lane merge helper.
   localparam int MAX_WIDTH = 128;
   localparam int MAX_MASK  = 32;

   typedef enum logic {
      IDLE,
      SWEEP
   } clr_state_t;

   // Bits per write lane (all lanes except possibly the top one).
   function automatic int chunk(input int width, input int mask);
      return (width + mask - 1) / mask;
   endfunction

   // Bits covered by the top write lane.
   function automatic int rest(input int width, input int mask);
      return width - (mask - 1) * chunk(width, mask);
   endfunction

   // Returns old_row with every lane whose mask bit is set replaced by new_row.
   // Bit b belongs to lane b / chunk_w; bits above the real row width are
   // discarded by the caller, so the short top lane needs no special case.
   function automatic logic [MAX_WIDTH-1:0] lane_merge(
      input logic [MAX_WIDTH-1:0] old_row,
      input logic [MAX_WIDTH-1:0] new_row,
      input logic [MAX_MASK-1:0]  mask,
      input int unsigned          chunk_w
   );
      logic [MAX_WIDTH-1:0] bit_en;
      bit_en = '0;
      for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
         if ((b / chunk_w) < MAX_MASK) bit_en[b] = mask[b / chunk_w];
      end
      return (new_row & bit_en) | (old_row & ~bit_en);
   endfunction

endpackage

// File: rtl/reg_mem_read_port.sv
// reg_mem_read_port
//    One registered read port of the register memory.
//    clk_i, rst_i : clock, synchronous active-high reset (clears data_o)
//    enable_i     : load data_o this cycle, otherwise hold
//    addr_i       : row address; rows >= HEIGHT read as zero
//    mem_i        : whole array contents
//    wr_valid_i, wr_addr_i, wr_row_i : the full row being written this cycle,
//                   forwarded to the read when WRITE_FIRST is set
//    data_o       : registered read data
module reg_mem_read_port
   import reg_mem_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int HEIGHT      = 16,
   parameter int AW          = 4,
   parameter bit WRITE_FIRST = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic [AW-1:0]                addr_i,
   input  logic [HEIGHT-1:0][WIDTH-1:0] mem_i,
   input  logic                         wr_valid_i,
   input  logic [AW-1:0]                wr_addr_i,
   input  logic [WIDTH-1:0]             wr_row_i,
   output logic [WIDTH-1:0]             data_o
);

   logic             in_range;
   logic [WIDTH-1:0] row_d;

   // With a power-of-two height every encodable address is a real row.
   if (HEIGHT == (1 << AW)) begin : g_full
      assign in_range = 1'b1;
   end else begin : g_partial
      assign in_range = ({1'b0, addr_i} < (AW + 1)'(HEIGHT));
   end

   always_comb begin
      // NOTE: default first so every path assigns row_d and no latch is inferred.
      row_d = '0;
      if (in_range) begin
         row_d = mem_i[addr_i];
         // wr_row_i is already the merged row, so unmasked lanes carry old data.
         if (WRITE_FIRST && wr_valid_i && (wr_addr_i == addr_i)) row_d = wr_row_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)         data_o <= '0;
      else if (enable_i) data_o <= row_d;
   end

endmodule

// File: rtl/reg_mem_mr_wm.sv
// reg_mem_mr_wm
//    Single-clock register memory: one lane-masked write port, READ_PORTS
//    registered read ports, selectable read-during-write, and a clear sweep
//    that writes CLEAR_VALUE to every row after reset and on request.
//    clk_i, rst_i   : clock, synchronous active-high reset (starts a sweep)
//    readEnable_i   : per-port read strobe
//    readAddr_i     : per-port read address
//    readData_o     : per-port registered read data
//    writeEnable_i, writeMask_i, writeAddr_i, writeData_i : masked write port
//    clear_i        : request a clear sweep
//    busy_o         : clear sweep in progress; user writes are dropped
module reg_mem_mr_wm
   import reg_mem_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               HEIGHT      = 16,
   parameter int               MASK        = 4,
   parameter int               READ_PORTS  = 2,
   parameter bit               WRITE_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
   localparam int              AW          = $clog2(HEIGHT)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [READ_PORTS-1:0]            readEnable_i,
   input  logic [READ_PORTS-1:0][AW-1:0]    readAddr_i,
   output logic [READ_PORTS-1:0][WIDTH-1:0] readData_o,
   input  logic                             writeEnable_i,
   input  logic [MASK-1:0]                  writeMask_i,
   input  logic [AW-1:0]                    writeAddr_i,
   input  logic [WIDTH-1:0]                 writeData_i,
   input  logic                             clear_i,
   output logic                             busy_o
);

   localparam int CHUNK = chunk(WIDTH, MASK);
   localparam int REST  = rest(WIDTH, MASK);

   if (REST < 1) begin : g_bad_rest
      $error("reg_mem_mr_wm: MASK=%0d leaves no bits for the top lane of WIDTH=%0d", MASK, WIDTH);
   end
   if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_ports
      $error("reg_mem_mr_wm: READ_PORTS=%0d outside 1..4", READ_PORTS);
   end
   if (HEIGHT < 2 || WIDTH > MAX_WIDTH || MASK > MAX_MASK) begin : g_bad_geom
      $error("reg_mem_mr_wm: unsupported HEIGHT/WIDTH/MASK combination");
   end

   logic [HEIGHT-1:0][WIDTH-1:0] mem_q;
   clr_state_t                   state;
   logic [AW-1:0]                clr_idx;

   logic                         wr_in_range;
   logic [WIDTH-1:0]             merged_row;
   logic                         wr_valid;
   logic [AW-1:0]                wr_addr;
   logic [WIDTH-1:0]             wr_row;

   if (HEIGHT == (1 << AW)) begin : g_wr_full
      assign wr_in_range = 1'b1;
   end else begin : g_wr_partial
      assign wr_in_range = ({1'b0, writeAddr_i} < (AW + 1)'(HEIGHT));
   end

   assign merged_row = WIDTH'(lane_merge(MAX_WIDTH'(mem_q[writeAddr_i]),
                                         MAX_WIDTH'(writeData_i),
                                         MAX_MASK'(writeMask_i),
                                         unsigned'(CHUNK)));

   // One array write per cycle: the sweep owns the port while busy. Nothing is
   // written during reset; the sweep that follows initialises every row.
   always_comb begin
      wr_valid = 1'b0;
      wr_addr  = writeAddr_i;
      wr_row   = merged_row;
      if (!rst_i) begin
         if (busy_o) begin
            wr_valid = 1'b1;
            wr_addr  = clr_idx;
            wr_row   = CLEAR_VALUE;
         end else if (writeEnable_i && wr_in_range) begin
            wr_valid = 1'b1;
         end
      end
   end

   // NOTE: the array is deliberately left without reset; the clear sweep
   // initialises it, which keeps the storage a plain register file.
   always_ff @(posedge clk_i) begin
      if (wr_valid) mem_q[wr_addr] <= wr_row;
   end

   // Clear FSM; busy_o is a register kept equal to (state == SWEEP).
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments so every reader
      // in this cycle sees the pre-edge value.
      if (rst_i) begin
         state   <= SWEEP;
         clr_idx <= '0;
         busy_o  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clear_i) begin
                  state   <= SWEEP;
                  clr_idx <= '0;
                  busy_o  <= 1'b1;
               end
            end
            SWEEP: begin
               if (clr_idx == AW'(HEIGHT - 1)) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      reg_mem_read_port #(
         .WIDTH       (WIDTH),
         .HEIGHT      (HEIGHT),
         .AW          (AW),
         .WRITE_FIRST (WRITE_FIRST)
      ) u_port (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .enable_i   (readEnable_i[p]),
         .addr_i     (readAddr_i[p]),
         .mem_i      (mem_q),
         .wr_valid_i (wr_valid),
         .wr_addr_i  (wr_addr),
         .wr_row_i   (wr_row),
         .data_o     (readData_o[p])
      );
   end

endmodule

// File: tb/tb_reg_mem_mr_wm.sv
// tb_reg_mem_mr_wm
//    Drives two instances from one stimulus stream: A is 32x16, four even
//    lanes, write-first, non-zero clear value; B is 10x12, uneven lanes
//    (CHUNK=3, top lane 1 bit), read-old, with out-of-range addresses.
//    Every edge both instances are compared with a row-level reference model.
module tb_reg_mem_mr_wm;

   localparam logic [31:0] A_CLR = 32'hC1EA_5EED;
   localparam logic [9:0]  B_CLR = 10'h2A5;

   logic              clk = 1'b0;
   logic              rst, clear, we;
   logic [3:0]        wmask, waddr;
   logic [31:0]       wdata;
   logic [1:0]        ren;
   logic [1:0][3:0]   raddr;
   logic [1:0][31:0]  a_rd;
   logic [1:0][9:0]   b_rd;
   logic              a_busy, b_busy;

   int vec_cnt = 0;
   int err_cnt = 0;
   int n;

   always #5 clk = ~clk;

   reg_mem_mr_wm #(
      .WIDTH(32), .HEIGHT(16), .MASK(4), .READ_PORTS(2),
      .WRITE_FIRST(1'b1), .CLEAR_VALUE(A_CLR)
   ) dut_a (
      .clk_i(clk), .rst_i(rst), .readEnable_i(ren), .readAddr_i(raddr),
      .readData_o(a_rd), .writeEnable_i(we), .writeMask_i(wmask),
      .writeAddr_i(waddr), .writeData_i(wdata), .clear_i(clear), .busy_o(a_busy)
   );

   reg_mem_mr_wm #(
      .WIDTH(10), .HEIGHT(12), .MASK(4), .READ_PORTS(2),
      .WRITE_FIRST(1'b0), .CLEAR_VALUE(B_CLR)
   ) dut_b (
      .clk_i(clk), .rst_i(rst), .readEnable_i(ren), .readAddr_i(raddr),
      .readData_o(b_rd), .writeEnable_i(we), .writeMask_i(wmask),
      .writeAddr_i(waddr), .writeData_i(wdata[9:0]), .clear_i(clear), .busy_o(b_busy)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic             busy;
      logic [3:0]       idx;
      logic [15:0][31:0] mem;
      logic [1:0][31:0] rd;
   } model_t;

   model_t ma, mb;

   // Lane l spans bits [l*chunk, min((l+1)*chunk, width)).
   function automatic logic [31:0] ref_merge(input logic [31:0] old_row,
                                             input logic [31:0] new_row,
                                             input logic [3:0] m, input int width);
      int chunk_w = (width + 3) / 4;
      logic [31:0] r = old_row;
      for (int lane = 0; lane < 4; lane++)
         if (m[lane])
            for (int b = lane * chunk_w; b < width && b < (lane + 1) * chunk_w; b++)
               r[b] = new_row[b];
      return r;
   endfunction

   // State of one instance after the coming edge, from the current inputs.
   function automatic model_t model_next(input model_t m, input int height,
                                         input int width, input bit wf,
                                         input logic [31:0] clr_val);
      model_t      nx = m;
      logic        user_ok;
      logic [31:0] row;
      logic [31:0] wd;
      wd = (width == 32) ? wdata : (wdata & ((32'd1 << width) - 32'd1));
      if (rst) begin
         nx.busy = 1'b1;
         nx.idx  = '0;
         nx.rd   = '0;
         return nx;
      end
      user_ok = we && !m.busy && (int'(waddr) < height);
      for (int p = 0; p < 2; p++) begin
         if (ren[p]) begin
            if (int'(raddr[p]) >= height) begin
               nx.rd[p] = '0;
            end else begin
               row = m.mem[raddr[p]];
               if (wf && user_ok && raddr[p] == waddr) row = ref_merge(row, wd, wmask, width);
               if (wf && m.busy && raddr[p] == m.idx) row = clr_val;
               nx.rd[p] = row;
            end
         end
      end
      if (user_ok) nx.mem[waddr] = ref_merge(m.mem[waddr], wd, wmask, width);
      if (m.busy) begin
         nx.mem[m.idx] = clr_val;
         if (int'(m.idx) == height - 1) nx.busy = 1'b0;
         else                           nx.idx  = m.idx + 4'd1;
      end else if (clear) begin
         nx.busy = 1'b1;
         nx.idx  = '0;
      end
      return nx;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      vec_cnt++;
      assert (observed === expected)
      else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One clock edge: advance the model, then compare everything 1 ns later.
   task automatic step();
      ma = model_next(ma, 16, 32, 1'b1, A_CLR);
      mb = model_next(mb, 12, 10, 1'b0, {22'b0, B_CLR});
      @(posedge clk);
      #1;
      check("a_busy", {31'b0, a_busy}, {31'b0, ma.busy});
      check("a_rd0", a_rd[0], ma.rd[0]);
      check("a_rd1", a_rd[1], ma.rd[1]);
      check("b_busy", {31'b0, b_busy}, {31'b0, mb.busy});
      check("b_rd0", {22'b0, b_rd[0]}, mb.rd[0]);
      check("b_rd1", {22'b0, b_rd[1]}, mb.rd[1]);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
      we = 1'b1; waddr = a; wdata = d; wmask = m;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a);
      ren = 2'b11; raddr[0] = a; raddr[1] = a;
      step();
      ren = 2'b00;
   endtask

   initial begin
      ma = '0; mb = '0;
      rst = 1'b1; clear = 1'b0; we = 1'b0; wmask = '0; waddr = '0; wdata = '0;
      ren = '0; raddr = '0;

      // Reset state.
      step();
      check("rst_busy", {31'b0, a_busy}, 32'd1);
      check("rst_rd0", a_rd[0], 32'd0);
      rst = 1'b0;

      // Reset sweep length, with a write to an already-swept row dropped.
      n = 0;
      while (a_busy && n < 64) begin
         we = (n == 5); waddr = 4'd0; wdata = 32'hDEAD_BEEF; wmask = 4'hF;
         step();
         n++;
      end
      we = 1'b0;
      check("reset_sweep_len", n, 32'd16);

      // Every row on every port holds the clear value; B rows >= 12 read zero.
      for (int r = 0; r < 16; r++) begin
         ren = 2'b11; raddr[0] = 4'(r); raddr[1] = 4'(15 - r);
         step();
         check("a_clr_row", a_rd[0], A_CLR);
         check("b_clr_row", {22'b0, b_rd[0]}, (r < 12) ? {22'b0, B_CLR} : 32'd0);
      end
      ren = 2'b00;

      // Masked write (B sees the low 10 bits on its 3/3/3/1 lanes).
      wr(4'd3, 32'hAABB_CCDD, 4'b1111);
      wr(4'd3, 32'h1122_3344, 4'b0101);
      rd(4'd3);
      check("a_mask_merge", a_rd[0], 32'hAA22_CC44);
      check("b_mask_merge", {22'b0, b_rd[1]}, 32'h15C);

      // Uneven top lane.
      wr(4'd4, 32'h0, 4'b1111);
      wr(4'd4, 32'h3FF, 4'b1000);
      rd(4'd4);
      check("b_top_lane", {22'b0, b_rd[0]}, 32'h200);

      // Read-during-write on both ports.
      wr(4'd5, 32'h0, 4'b1111);
      we = 1'b1; waddr = 4'd5; wdata = 32'hFFFF_FFFF; wmask = 4'b0011;
      ren = 2'b11; raddr[0] = 4'd5; raddr[1] = 4'd5;
      step();
      we = 1'b0; ren = 2'b00;
      check("a_rdw_p0", a_rd[0], 32'h0000_FFFF);
      check("a_rdw_p1", a_rd[1], 32'h0000_FFFF);
      check("b_rdw_p0", {22'b0, b_rd[0]}, 32'h0);
      check("b_rdw_p1", {22'b0, b_rd[1]}, 32'h0);
      rd(4'd5);
      check("b_after_rdw", {22'b0, b_rd[0]}, 32'h03F);

      // Port 1 disabled holds its data across writes to the row.
      wr(4'd6, 32'h1234_5678, 4'b1111);
      rd(4'd6);
      ren = 2'b01; raddr[0] = 4'd6; raddr[1] = 4'd6;
      wr(4'd6, 32'h9ABC_DEF0, 4'b1111);
      check("a_hold_p1", a_rd[1], 32'h1234_5678);
      check("a_fwd_p0", a_rd[0], 32'h9ABC_DEF0);
      ren = 2'b00;

      // Clear with a same-cycle write; second clear mid-sweep is ignored.
      clear = 1'b1;
      wr(4'd2, 32'h5, 4'b1111);
      clear = 1'b0;
      n = 0;
      while (a_busy && n < 64) begin
         clear = (n == 4);
         ren = 2'b11; raddr[0] = 4'(n); raddr[1] = 4'($urandom_range(0, 15));
         step();
         check("a_sweep_fwd", a_rd[0], A_CLR);
         n++;
      end
      clear = 1'b0; ren = 2'b00;
      check("clear_sweep_len", n, 32'd16);
      rd(4'd2);
      check("a_clear_row2", a_rd[0], A_CLR);
      check("b_clear_row2", {22'b0, b_rd[0]}, {22'b0, B_CLR});

      // Reset at sweep row 7 restarts a full sweep.
      clear = 1'b1;
      step();
      clear = 1'b0;
      ren = 2'b11; raddr[0] = 4'd3; raddr[1] = 4'd9;
      for (int i = 0; i < 7; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0; ren = 2'b00;
      check("mid_rst_rd0", a_rd[0], 32'd0);
      check("mid_rst_rd1", a_rd[1], 32'd0);
      n = 0;
      while (a_busy && n < 64) begin
         step();
         n++;
      end
      check("mid_rst_sweep_len", n, 32'd16);

      // Randomised traffic with occasional clears and resets.
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         clear = ($urandom_range(0, 59) == 0);
         we    = !rst && ($urandom_range(0, 1) == 1);
         waddr = 4'($urandom_range(0, 15));
         wdata = $urandom;
         wmask = 4'($urandom_range(0, 15));
         ren   = 2'($urandom_range(0, 3));
         raddr[0] = 4'($urandom_range(0, 15));
         raddr[1] = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom_range(0, 15));
         step();
      end
      rst = 1'b0; clear = 1'b0; we = 1'b0; ren = 2'b00;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
